// File: rtl/lvdc_din_tx.sv
// Serial word transmitter for the LVDC DIN line: lead-in, MSB-first data,
// odd parity, terminate strobe and an end-of-transfer pulse. Freezable by HOLD.
module lvdc_din_tx #(
  parameter int WORD_W  = 26,
  parameter int DIV     = 4,
  parameter int INTC_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [WORD_W-1:0] WORD,
  input  logic              HOLD,
  output logic              DIN,
  output logic              DATAV,
  output logic              TER,
  output logic              INTCV,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_PARITY, S_TERM, S_FINISH
  } state_t;

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  // Parity bit that makes the total number of ones over data+parity odd.
  function automatic logic odd_parity(input logic [WORD_W-1:0] w);
    return ~(^w);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              din_q, din_d;
  logic              datav_q, datav_d;
  logic              ter_q, ter_d;
  logic              intcv_q, intcv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      din_q   <= 1'b0;
      datav_q <= 1'b0;
      ter_q   <= 1'b0;
      intcv_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      din_q   <= din_d;
      datav_q <= datav_d;
      ter_q   <= ter_d;
      intcv_q <= intcv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST) && !HOLD;

  // Next state: the bit timer gates every advance; HOLD stalls it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sh_d    = WORD;
          par_d   = odd_parity(WORD);
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_LEAD;
        end
      end
      S_LEAD, S_SHIFT, S_PARITY, S_TERM: begin
        if (!HOLD) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          unique case (state_q)
            S_LEAD:   state_d = S_SHIFT;
            S_SHIFT: begin
              if (bit_q == BIT_LAST) begin
                bit_d   = '0;
                state_d = S_PARITY;
              end else begin
                bit_d = bit_q + BIT_W'(1);
                sh_d  = sh_q << 1;
              end
            end
            S_PARITY: state_d = S_TERM;
            default:  state_d = S_FINISH;
          endcase
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    din_d   = 1'b0;
    datav_d = 1'b0;
    ter_d   = 1'b0;
    intcv_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_LEAD:   datav_d = 1'b1;
      S_SHIFT: begin
        datav_d = 1'b1;
        din_d   = sh_d[WORD_W-1];
      end
      S_PARITY: begin
        datav_d = 1'b1;
        din_d   = par_d;
      end
      S_TERM:   ter_d = 1'b1;
      S_FINISH: begin
        done_d  = 1'b1;
        intcv_d = (INTC_EN != 0);
      end
      default:  ;
    endcase
  end

  assign DIN   = din_q;
  assign DATAV = datav_q;
  assign TER   = ter_q;
  assign INTCV = intcv_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_lvdc_din_tx.sv
// Bench for lvdc_din_tx: default configuration plus a DIV=2/WORD_W=8/INTC_EN=0
// instance, both compared cycle by cycle against a transfer-position model.
module tb_lvdc_din_tx;

  localparam int DIV_A = 4, WW_A = 26, FIN_A = DIV_A * (WW_A + 3) + 1;
  localparam int DIV_B = 2, WW_B = 8,  FIN_B = DIV_B * (WW_B + 3) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, hold_a = 1'b0;
  logic [25:0] word_a = '0;
  logic        start_b = 1'b0, hold_b = 1'b0;
  logic [7:0]  word_b = '0;
  logic din_a, datav_a, ter_a, intcv_a, busy_a, done_a;
  logic din_b, datav_b, ter_b, intcv_b, busy_b, done_b;

  int n_cmp = 0, n_bad = 0;
  int ka = 0, kb = 0;
  logic [31:0] wa = '0, wb = '0;
  int cyc_a = 0, cyc_b = 0, done_at_a = -1, done_at_b = -1, intcv_cnt_b = 0;

  always #5 clk = ~clk;

  lvdc_din_tx u_a (
    .CLK(clk), .RST(rst), .START(start_a), .WORD(word_a), .HOLD(hold_a),
    .DIN(din_a), .DATAV(datav_a), .TER(ter_a), .INTCV(intcv_a), .BUSY(busy_a), .DONE(done_a)
  );

  lvdc_din_tx #(.WORD_W(8), .DIV(2), .INTC_EN(0)) u_b (
    .CLK(clk), .RST(rst), .START(start_b), .WORD(word_b), .HOLD(hold_b),
    .DIN(din_b), .DATAV(datav_b), .TER(ter_b), .INTCV(intcv_b), .BUSY(busy_b), .DONE(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // k = 0 idle, else the k-th cycle after acceptance; returns {busy,done,intcv,ter,datav,din}.
  function automatic logic [5:0] model_out(int k, logic [31:0] w, int div, int ww, bit intc);
    int fin, p, ones;
    logic d;
    fin = div * (ww + 3) + 1;
    if (k == 0) return 6'b0;
    if (k == fin) return {1'b1, 1'b1, intc, 3'b000};
    p = (k - 1) / div;
    ones = 0;
    for (int i = 0; i < ww; i++) ones += int'(w[i]);
    d = 1'b0;
    if (p >= 1 && p <= ww) d = w[ww - p];
    else if (p == ww + 1) d = (ones % 2 == 0);
    return {1'b1, 1'b0, 1'b0, (p == ww + 2), (p <= ww + 1), d};
  endfunction

  function automatic int next_k(int k, bit r, bit s, bit h, int fin);
    if (r) return 0;
    if (k == 0) return s ? 1 : 0;
    if (k == fin) return 0;
    return h ? k : k + 1;
  endfunction

  task automatic step();
    bit acc_a, acc_b;
    @(posedge clk);
    acc_a = (ka == 0) && !rst && start_a;
    acc_b = (kb == 0) && !rst && start_b;
    if (acc_a) wa = 32'(word_a);
    if (acc_b) wb = 32'(word_b);
    ka = next_k(ka, rst, start_a, hold_a, FIN_A);
    kb = next_k(kb, rst, start_b, hold_b, FIN_B);
    cyc_a = acc_a ? 1 : cyc_a + 1;
    cyc_b = acc_b ? 1 : cyc_b + 1;
    #1;
    check_eq($sformatf("A k=%0d", ka), {26'b0, busy_a, done_a, intcv_a, ter_a, datav_a, din_a},
             {26'b0, model_out(ka, wa, DIV_A, WW_A, 1'b1)});
    check_eq($sformatf("B k=%0d", kb), {26'b0, busy_b, done_b, intcv_b, ter_b, datav_b, din_b},
             {26'b0, model_out(kb, wb, DIV_B, WW_B, 1'b0)});
    if (done_a) done_at_a = cyc_a;
    if (done_b) done_at_b = cyc_b;
    if (intcv_b) intcv_cnt_b++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_a(input logic [25:0] w);
    word_a = w; start_a = 1'b1; step(); start_a = 1'b0;
    word_a = 26'($urandom);
  endtask

  initial begin
    run(3);
    rst = 1'b0;
    step();

    done_at_a = -1;
    pulse_a(26'h2AAAAAA); run(118);
    check_eq("A_done_cycle_default", 32'(done_at_a), 32'd117);

    pulse_a(26'h0000000); run(118);
    pulse_a(26'h3FFFFFF); run(118);

    done_at_a = -1;
    pulse_a(26'h155AA53); run(40);
    hold_a = 1'b1; run(10); hold_a = 1'b0;
    run(90);
    check_eq("A_done_cycle_hold", 32'(done_at_a), 32'd127);

    pulse_a(26'h1234567);
    for (int i = 2; i <= 125; i++) begin
      start_a = (i == 6 || i == 61 || i == 118 || i == 119);
      word_a  = 26'($urandom);
      step();
    end
    start_a = 1'b0;
    run(120);

    done_at_a = -1;
    pulse_a(26'h3C0F0F1); run(49);
    rst = 1'b1; step(); rst = 1'b0;
    run(130);
    check_eq("A_no_done_after_reset", 32'(done_at_a), 32'hFFFFFFFF);
    pulse_a(26'h0F0F0F0); run(118);

    done_at_b = -1; intcv_cnt_b = 0;
    word_b = 8'h81; start_b = 1'b1; step(); start_b = 1'b0;
    run(24);
    check_eq("B_done_cycle", 32'(done_at_b), 32'd23);
    check_eq("B_intcv_count", 32'(intcv_cnt_b), 32'd0);

    // Random traffic with holds, stray starts and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 599) == 0);
      start_a = ($urandom_range(0, 30) == 0);
      start_b = ($urandom_range(0, 10) == 0);
      hold_a  = ($urandom_range(0, 5) == 0);
      hold_b  = ($urandom_range(0, 4) == 0);
      word_a  = 26'($urandom);
      word_b  = 8'($urandom);
      step();
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    run(130);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
